full_adder: RTL and testbench



---
 rtl/full_adder.sv | 71 +++++++
 tb/tb_full_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, with signed overflow.
// Results appear one cycle after in_valid; registers hold while in_valid is low.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] sum_calc;
  logic             carry;
  logic             carry_into_msb;

  logic [WIDTH-1:0] sum_d,  sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d,  ovf_q;
  logic             out_valid_d, out_valid_q;

  // Ripple chain of per-bit full-adder cells; carry_into_msb feeds the overflow flag.
  always_comb begin
    carry          = cin;
    carry_into_msb = cin;
    sum_calc       = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      carry_into_msb = carry;
      sum_calc[i]    = a[i] ^ b[i] ^ carry;
      carry          = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  // Operands only reach the registers when in_valid is high, so junk on idle inputs is ignored.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_calc;
      cout_d = carry;
      ovf_d  = carry ^ carry_into_msb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=4 instances against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ov1, s1, co1, of1;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov4, co4, of4;
  logic [3:0] s4;

  logic [3:0] exp1;  // {out_valid, cout, ovf, sum}
  logic [6:0] exp4;  // {out_valid, cout, ovf, sum[3:0]}

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1)
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .sum(s4), .cout(co4), .ovf(of4)
  );

  wire [3:0] obs1 = {ov1, co1, of1, s1};
  wire [6:0] obs4 = {ov4, co4, of4, s4};

  // Reference: plain integer addition; overflow when same-sign operands give an opposite-sign sum.
  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int unsigned t;
    logic [3:0]  s;
    t = int'(a) + int'(b) + int'(c);
    s = t[3:0];
    return {t[4], (a[3] == b[3]) && (s[3] != a[3]), s};
  endfunction

  function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return {t[1], (a == b) && (t[0] != a), t[0]};
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model; sample lands 1ns after the edge.
  task automatic step(input logic r,
                      input logic iv1, input logic ia1, input logic ib1, input logic ic1,
                      input logic iv4, input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4);
    rst = r;
    v1 = iv1; a1 = ia1; b1 = ib1; c1 = ic1;
    v4 = iv4; a4 = ia4; b4 = ib4; c4 = ic4;
    @(posedge clk);
    #1;
    if (r)        exp1 = '0;
    else if (iv1) exp1 = {1'b1, model1(ia1, ib1, ic1)};
    else          exp1[3] = 1'b0;
    if (r)        exp4 = '0;
    else if (iv4) exp4 = {1'b1, model4(ia4, ib4, ic4)};
    else          exp4[6] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1);
      n_checks += 2;
      if (obs1 !== 4'b0000) begin n_fail++; $display("FAIL reset_w1 cyc%0d: got %b want 0000", k, obs1); end
      if (obs4 !== 7'b0)    begin n_fail++; $display("FAIL reset_w4 cyc%0d: got %b want 0000000", k, obs4); end
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] cs_tab [8];
    logic [2:0] abc;
    logic [3:0] want;
    cs_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int k = 0; k < 8; k++) begin
      abc = 3'(k);
      step(1'b0, 1'b1, abc[2], abc[1], abc[0], 1'b0, 4'h0, 4'h0, 1'b0);
      want = {1'b1, cs_tab[k][1], cs_tab[k][1] ^ abc[0], cs_tab[k][0]};
      n_checks++;
      if (obs1 !== want) begin n_fail++; $display("FAIL exhaustive_w1 abc=%b: got %b want %b", abc, obs1, want); end
    end
  endtask

  task automatic test_carry_ripple();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    n_checks++;
    if (obs4 !== 7'b1100000) begin n_fail++; $display("FAIL carry_ripple: got %b want 1100000", obs4); end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0);
    n_checks++;
    if (obs4 !== 7'b1011000) begin n_fail++; $display("FAIL ovf_pos: got %b want 1011000", obs4); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 4'h8, 1'b0);
    n_checks++;
    if (obs4 !== 7'b1110000) begin n_fail++; $display("FAIL ovf_neg: got %b want 1110000", obs4); end
  endtask

  task automatic test_hold_gap();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3, 1'b0);
    n_checks++;
    if (obs4 !== 7'b1000101) begin n_fail++; $display("FAIL gap_first: got %b want 1000101", obs4); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 4'h3, 1'b0);
      n_checks++;
      if (obs4 !== 7'b0000101) begin n_fail++; $display("FAIL gap_hold cyc%0d: got %b want 0000101", k, obs4); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h3, 1'b0);
    n_checks++;
    if (obs4 !== 7'b1001101) begin n_fail++; $display("FAIL gap_pulse: got %b want 1001101", obs4); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h3, 1'b0);
    n_checks++;
    if (obs4 !== 7'b0001101) begin n_fail++; $display("FAIL gap_after: got %b want 0001101", obs4); end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
    n_checks += 2;
    if (obs4 !== 7'b0) begin n_fail++; $display("FAIL rst_mid_w4: got %b want 0000000", obs4); end
    if (obs1 !== 4'b0) begin n_fail++; $display("FAIL rst_mid_w1: got %b want 0000", obs1); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h4, 1'b0);
      n_checks++;
      if (obs4 !== 7'b0) begin n_fail++; $display("FAIL rst_no_late cyc%0d: got %b want 0000000", k, obs4); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
    n_checks++;
    if (obs4 !== 7'b1000111) begin n_fail++; $display("FAIL rst_recover: got %b want 1000111", obs4); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
           1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
      n_checks += 2;
      if (obs4 !== exp4) begin n_fail++; $display("FAIL b2b_w4 k=%0d: got %b want %b", k, obs4, exp4); end
      if (obs1 !== exp1) begin n_fail++; $display("FAIL b2b_w1 k=%0d: got %b want %b", k, obs1, exp1); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
      n_checks += 2;
      if (obs4 !== exp4) begin n_fail++; $display("FAIL random_w4 k=%0d: got %b want %b", k, obs4, exp4); end
      if (obs1 !== exp1) begin n_fail++; $display("FAIL random_w1 k=%0d: got %b want %b", k, obs1, exp1); end
    end
  endtask

  initial begin
    exp1 = '0;
    exp4 = '0;
    test_reset();
    test_exhaustive_w1();
    test_carry_ripple();
    test_overflow();
    test_hold_gap();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
